// File: rtl/x87_encode.sv
// x87_encode: turns an x87 command code (same numbering as the x87 decoder)
// into its opcode byte stream. The stream uses a valid/ready handshake on the
// output side.
// Optional feature: define X87_ENC_FWAIT_PREFIX_EN to precede every valid
// non-FWAIT instruction with a 9B (FWAIT) prefix byte.
module x87_encode (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_cmd,
  input  logic [3:0] in_idx,
  input  logic [7:0] in_modrm,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef X87_ENC_FWAIT_PREFIX_EN
    PFX  = 2'd1,
`endif
    B0   = 2'd2,
    B1   = 2'd3
  } state_t;

  state_t     state;
  logic       dec_ok;
  logic       dec_two;
  logic [7:0] dec_b0;
  logic [7:0] dec_b1;
  logic [4:0] rbase;
  logic [2:0] mreg;
  logic       is_reg;
  logic       is_mem;
  logic [7:0] hold_b1;
  logic       hold_two;
`ifdef X87_ENC_FWAIT_PREFIX_EN
  logic [7:0] hold_b0;
`endif

  // Decode the offered command into its opcode bytes and a validity flag.
  always_comb begin
    dec_ok  = 1'b1;
    dec_two = 1'b1;
    dec_b0  = 8'h00;
    dec_b1  = 8'h00;
    rbase   = 5'h00;
    mreg    = 3'd0;
    is_reg  = 1'b0;
    is_mem  = 1'b0;
    case (in_cmd)
      5'd1:  begin dec_b0 = 8'hDF; dec_b1 = 8'hE0; end
      5'd2:  begin dec_b0 = 8'hDB; dec_b1 = 8'hE3; end
      5'd3:  begin dec_b0 = 8'hD9; mreg = 3'd5; is_mem = 1'b1; end
      5'd4:  begin dec_b0 = 8'hD9; mreg = 3'd7; is_mem = 1'b1; end
      5'd5:  begin dec_b0 = 8'h9B; dec_two = 1'b0; end
      5'd6:  begin dec_b0 = 8'hD9; mreg = 3'd0; is_mem = 1'b1; end
      5'd7:  begin dec_b0 = 8'hDD; mreg = 3'd0; is_mem = 1'b1; end
      5'd8:  begin dec_b0 = 8'hD9; mreg = 3'd3; is_mem = 1'b1; end
      5'd9:  begin dec_b0 = 8'hDD; mreg = 3'd3; is_mem = 1'b1; end
      5'd10: begin dec_b0 = 8'hD9; rbase = 5'h18; is_reg = 1'b1; end
      5'd11: begin dec_b0 = 8'hD9; rbase = 5'h19; is_reg = 1'b1; end
      5'd12: begin dec_b0 = 8'hDD; rbase = 5'h1B; is_reg = 1'b1; end
      5'd13: begin dec_b0 = 8'hDE; rbase = 5'h1C; is_reg = 1'b1; end
      5'd14: begin dec_b0 = 8'hDE; rbase = 5'h1D; is_reg = 1'b1; end
      5'd15: begin dec_b0 = 8'hDE; rbase = 5'h1F; is_reg = 1'b1; end
      5'd16: begin dec_b0 = in_idx[0] ? 8'hDB : 8'hDF; mreg = 3'd0; is_mem = 1'b1; end
      5'd17: begin dec_b0 = in_idx[0] ? 8'hDB : 8'hDF; mreg = 3'd2; is_mem = 1'b1; end
      5'd18: begin dec_b0 = in_idx[0] ? 8'hDB : 8'hDF; mreg = 3'd3; is_mem = 1'b1; end
      5'd19: begin dec_b0 = 8'hD9; dec_b1 = in_idx[0] ? 8'hF5 : 8'hF8; end
      5'd20: begin dec_b0 = 8'hD8; rbase = 5'h18; is_reg = 1'b1; end
      5'd21: begin dec_b0 = 8'hD8; rbase = 5'h19; is_reg = 1'b1; end
      5'd22: begin dec_b0 = 8'hD8; rbase = 5'h1E; is_reg = 1'b1; end
      5'd23: begin dec_b0 = 8'hD8; rbase = 5'h1A; is_reg = 1'b1; end
      5'd24: begin dec_b0 = 8'hD8; rbase = 5'h1C; is_reg = 1'b1; end
      5'd25: begin dec_b0 = 8'hD8; rbase = 5'h1D; is_reg = 1'b1; end
      5'd26: begin dec_b0 = 8'hD8; rbase = 5'h1B; is_reg = 1'b1; end
      5'd27: begin dec_b0 = 8'hDE; rbase = 5'h18; is_reg = 1'b1; end
      5'd28: begin dec_b0 = 8'hDE; rbase = 5'h19; is_reg = 1'b1; end
      5'd29: begin dec_b0 = 8'hDE; rbase = 5'h1E; is_reg = 1'b1; end
      5'd30: begin dec_b0 = 8'hD8; rbase = 5'h1F; is_reg = 1'b1; end
      5'd31: begin
        dec_b0 = 8'hD9;
        case (in_idx)
          4'd0:    dec_b1 = 8'hE0;
          4'd1:    dec_b1 = 8'hE1;
          4'd2:    dec_b1 = 8'hE4;
          4'd3:    dec_b1 = 8'hE5;
          4'd4:    dec_b1 = 8'hFA;
          4'd5:    dec_b1 = 8'hFC;
          4'd6:    dec_b1 = 8'hFD;
          4'd7:    dec_b1 = 8'hF4;
          4'd8:    dec_b1 = 8'hF0;
          4'd9:    dec_b1 = 8'hF1;
          4'd10:   dec_b1 = 8'hF9;
          default: dec_ok = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
    // Memory forms keep mod/rm and substitute the opcode extension in [5:3].
    if (is_mem) begin
      dec_b1 = {in_modrm[7:6], mreg, in_modrm[2:0]};
      if (in_modrm[7:6] == 2'b11) dec_ok = 1'b0;
    end
    // Register forms only address ST(0)..ST(7).
    if (is_reg) begin
      dec_b1 = {rbase, in_idx[2:0]};
      if (in_idx[3]) dec_ok = 1'b0;
    end
  end

  // Holding registers for bytes not yet presented; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_ready && in_valid) begin
      hold_b1  <= dec_b1;
      hold_two <= dec_two;
`ifdef X87_ENC_FWAIT_PREFIX_EN
      hold_b0  <= dec_b0;
`endif
    end
  end

  // Control FSM with registered handshake and stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            if (!dec_ok) begin
              err <= 1'b1;
            end else begin
              out_valid <= 1'b1;
`ifdef X87_ENC_FWAIT_PREFIX_EN
              if (dec_two) begin
                state    <= PFX;
                out_byte <= 8'h9B;
                out_last <= 1'b0;
              end else begin
                state    <= B0;
                out_byte <= dec_b0;
                out_last <= 1'b1;
              end
`else
              state    <= B0;
              out_byte <= dec_b0;
              out_last <= !dec_two;
`endif
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
`ifdef X87_ENC_FWAIT_PREFIX_EN
        PFX: begin
          if (out_valid && out_ready) begin
            state    <= B0;
            out_byte <= hold_b0;
            out_last <= !hold_two;
          end
        end
`endif
        B0: begin
          if (out_valid && out_ready) begin
            if (hold_two) begin
              state    <= B1;
              out_byte <= hold_b1;
              out_last <= 1'b1;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
            end
          end
        end
        B1: begin
          if (out_valid && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x87_encode.sv
// Testbench for x87_encode: directed cases followed by random commands,
// checked against a table-driven model of the x87 opcode map.
module tb_x87_encode;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_cmd;
  logic [3:0] in_idx;
  logic [7:0] in_modrm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] misc_tbl [0:10] = '{8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hFA, 8'hFC,
                                  8'hFD, 8'hF4, 8'hF0, 8'hF1, 8'hF9};

  x87_encode dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cmd   (in_cmd),
    .in_idx   (in_idx),
    .in_modrm (in_modrm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .out_last (out_last),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Expected byte sequence from the x87 opcode map; ok=0 for unencodable.
  task automatic model(input int cmd, input int idx, input logic [7:0] modrm,
                       output bit ok);
    int op;
    int rg;
    int base;
    ok = 1;
    op = -1; rg = -1; base = -1;
    exp_q.delete();
    case (cmd)
      1:  begin exp_q.push_back(8'hDF); exp_q.push_back(8'hE0); end
      2:  begin exp_q.push_back(8'hDB); exp_q.push_back(8'hE3); end
      5:  exp_q.push_back(8'h9B);
      3:  begin op = 'hD9; rg = 5; end
      4:  begin op = 'hD9; rg = 7; end
      6:  begin op = 'hD9; rg = 0; end
      7:  begin op = 'hDD; rg = 0; end
      8:  begin op = 'hD9; rg = 3; end
      9:  begin op = 'hDD; rg = 3; end
      16: begin op = (idx % 2 == 1) ? 'hDB : 'hDF; rg = 0; end
      17: begin op = (idx % 2 == 1) ? 'hDB : 'hDF; rg = 2; end
      18: begin op = (idx % 2 == 1) ? 'hDB : 'hDF; rg = 3; end
      10: begin op = 'hD9; base = 'hC0; end
      11: begin op = 'hD9; base = 'hC8; end
      12: begin op = 'hDD; base = 'hD8; end
      13: begin op = 'hDE; base = 'hE0; end
      14: begin op = 'hDE; base = 'hE8; end
      15: begin op = 'hDE; base = 'hF8; end
      27: begin op = 'hDE; base = 'hC0; end
      28: begin op = 'hDE; base = 'hC8; end
      29: begin op = 'hDE; base = 'hF0; end
      20: begin op = 'hD8; base = 'hC0; end
      21: begin op = 'hD8; base = 'hC8; end
      22: begin op = 'hD8; base = 'hF0; end
      23: begin op = 'hD8; base = 'hD0; end
      24: begin op = 'hD8; base = 'hE0; end
      25: begin op = 'hD8; base = 'hE8; end
      26: begin op = 'hD8; base = 'hD8; end
      30: begin op = 'hD8; base = 'hF8; end
      19: begin
        exp_q.push_back(8'hD9);
        exp_q.push_back((idx % 2 == 1) ? 8'hF5 : 8'hF8);
      end
      31: begin
        if (idx > 10) ok = 0;
        else begin exp_q.push_back(8'hD9); exp_q.push_back(misc_tbl[idx]); end
      end
      default: ok = 0;
    endcase
    if (rg >= 0) begin
      if (modrm >= 8'hC0) ok = 0;
      else begin
        exp_q.push_back(8'(op));
        exp_q.push_back((modrm & 8'hC7) | 8'(rg * 8));
      end
    end
    if (base >= 0) begin
      if (idx >= 8) ok = 0;
      else begin
        exp_q.push_back(8'(op));
        exp_q.push_back(8'(base + idx));
      end
    end
`ifdef X87_ENC_FWAIT_PREFIX_EN
    if (ok && cmd != 5) exp_q.push_front(8'h9B);
`endif
    if (!ok) exp_q.delete();
  endtask

  // Offer one command, then drain its bytes. mode: 0 always ready,
  // 1 ready toggling starting low, 2 random ready. Called at a negedge.
  task automatic run_cmd(input int cmd, input int idx, input logic [7:0] modrm,
                         input int mode);
    bit ok;
    int k;
    int cyc;
    bit tog;
    model(cmd, idx, modrm, ok);
    check1("in_ready_before", in_ready, 1'b1);
    in_valid = 1'b1;
    in_cmd   = 5'(cmd);
    in_idx   = 4'(idx);
    in_modrm = modrm;
    @(negedge clk);
    in_valid = 1'b0;
    in_cmd   = 5'($urandom);
    in_idx   = 4'($urandom);
    in_modrm = 8'($urandom);
    if (!ok) begin
      check1("err_pulse", err, 1'b1);
      check1("no_valid_on_err", out_valid, 1'b0);
      @(negedge clk);
      check1("err_cleared", err, 1'b0);
      check1("no_valid_after_err", out_valid, 1'b0);
      check1("ready_after_err", in_ready, 1'b1);
    end else begin
      k = 0; cyc = 0; tog = 1'b0;
      while (k < exp_q.size() && cyc < 64) begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       begin out_ready = tog; tog = !tog; end
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        check1("out_valid", out_valid, 1'b1);
        check8("out_byte", out_byte, exp_q[k]);
        check1("out_last", out_last, k == exp_q.size() - 1);
        check1("busy_in_ready", in_ready, 1'b0);
        check1("no_err", err, 1'b0);
        if (out_ready) k++;
        @(negedge clk);
        cyc++;
      end
      check8("bytes_done", 8'(k), 8'(exp_q.size()));
      out_ready = 1'b0;
      check1("valid_drop", out_valid, 1'b0);
      check1("ready_return", in_ready, 1'b1);
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_idx = '0; in_modrm = '0;
    out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check8("rst_out_byte", out_byte, 8'h00);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", in_ready, 1'b1);

    run_cmd(20, 3, 8'h00, 0);
    run_cmd(16, 1, 8'h06, 0);
    run_cmd(18, 0, 8'h45, 0);
    run_cmd(31, 9, 8'h00, 1);
    run_cmd(0, 0, 8'h00, 0);
    run_cmd(31, 11, 8'h00, 0);
    run_cmd(6, 0, 8'hC0, 0);
    run_cmd(2, 0, 8'h00, 1);
    run_cmd(5, 0, 8'h00, 1);
    run_cmd(19, 0, 8'h00, 2);
    run_cmd(19, 1, 8'h00, 2);
    run_cmd(13, 8, 8'h00, 0);
    run_cmd(17, 2, 8'hBF, 2);

    // Reset in the middle of cmd=11 idx=2, right after D9 is taken.
    in_valid = 1'b1; in_cmd = 5'd11; in_idx = 4'd2; in_modrm = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (out_valid && out_byte == 8'hD9) seen = 1'b1;
      @(negedge clk);
    end
    check1("saw_d9", seen, 1'b1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check8("midrst_out_byte", out_byte, 8'h00);
    check1("midrst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("ready_after_midrst", in_ready, 1'b1);
    run_cmd(11, 2, 8'h00, 0);

    for (int n = 0; n < 120; n++) begin
      run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
              8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
